// File: rtl/rst_seq_ctrl.sv
// Reset arbiter and staged-release sequencer: merges ext/sw/soft/watchdog requests,
// holds all domains in reset, then releases them in order. Watchdog built under RST_SEQ_WDT_EN.
module rst_seq_ctrl #(
   parameter int CLK_DIV = 1000,
   parameter int STAGES  = 3,
   parameter int T_HOLD  = 200,
   parameter int T_GAP   = 100,
   parameter int T_WDT   = 1600
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ext_rst_n,
   input  logic              sw_rst_n,
   input  logic              soft_rst_n,
   input  logic              wdi,
   output logic [STAGES-1:0] stage_rst_n,
   output logic [2:0]        cause,
   output logic              busy
);

`ifdef RST_SEQ_WDT_EN
   localparam bit WDT_ON = 1'b1;
   localparam int TMAX0  = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
   localparam int TMAX   = (TMAX0 > T_WDT) ? TMAX0 : T_WDT;
`else
   localparam bit WDT_ON = 1'b0;
   localparam int TMAX   = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
   localparam int unused_t_wdt = T_WDT;
`endif

   localparam int PW = $clog2(CLK_DIV);
   localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam int KW = (STAGES > 1) ? $clog2(STAGES) : 1;

   localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_DIV - 1);
   localparam logic [TW-1:0] HOLD_LAST = TW'(T_HOLD - 1);
   localparam logic [TW-1:0] GAP_LAST  = TW'(T_GAP - 1);
   localparam logic [KW-1:0] K_LAST    = KW'(STAGES - 1);

   localparam logic [2:0] C_POR  = 3'd0;
   localparam logic [2:0] C_EXT  = 3'd1;
   localparam logic [2:0] C_SW   = 3'd2;
   localparam logic [2:0] C_WDT  = 3'd3;
   localparam logic [2:0] C_SOFT = 3'd4;

   typedef enum logic [1:0] {HOLD, REL, RUN} state_t;

   state_t            state, state_nxt;
   logic [STAGES-1:0] stage_nxt;
   logic [2:0]        cause_nxt;
   logic              busy_nxt;
   logic [KW-1:0]     k, k_nxt;
   logic [PW-1:0]     pre, pre_nxt;
   logic [TW-1:0]     tcnt, tcnt_nxt;
   logic              clr;

   logic ext_p0, ext_p1, sw_p0, sw_p1;
   logic soft_p0, soft_p1, soft_p2;
   logic tick, req_ext, req_sw, req_soft, req_wdt, req, kick;

   // Synchronizers idle high so a reset never leaves a phantom request behind
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         ext_p0  <= 1'b1;
         ext_p1  <= 1'b1;
         sw_p0   <= 1'b1;
         sw_p1   <= 1'b1;
         soft_p0 <= 1'b1;
         soft_p1 <= 1'b1;
         soft_p2 <= 1'b1;
      end else begin
         ext_p0  <= ext_rst_n;
         ext_p1  <= ext_p0;
         sw_p0   <= sw_rst_n;
         sw_p1   <= sw_p0;
         soft_p0 <= soft_rst_n;
         soft_p1 <= soft_p0;
         soft_p2 <= soft_p1;
      end
   end

   assign tick     = (pre == PRE_LAST);
   assign req_ext  = ~ext_p1;
   assign req_sw   = ~sw_p1;
   assign req_soft = soft_p2 & ~soft_p1;
   assign req      = req_ext | req_sw | req_soft | req_wdt;

`ifdef RST_SEQ_WDT_EN
   localparam logic [TW-1:0] WDT_LAST = TW'(T_WDT - 1);
   logic wdi_p0, wdi_p1, wdi_p2;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         wdi_p0 <= 1'b0;
         wdi_p1 <= 1'b0;
         wdi_p2 <= 1'b0;
      end else begin
         wdi_p0 <= wdi;
         wdi_p1 <= wdi_p0;
         wdi_p2 <= wdi_p1;
      end
   end

   assign kick    = (state == RUN) && (wdi_p2 ^ wdi_p1);
   assign req_wdt = (state == RUN) && tick && (tcnt == WDT_LAST);
`else
   logic unused_wdi;
   assign unused_wdi = wdi;
   assign kick       = 1'b0;
   assign req_wdt    = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state       <= HOLD;
         stage_rst_n <= '0;
         cause       <= C_POR;
         busy        <= 1'b1;
         k           <= '0;
         pre         <= '0;
         tcnt        <= '0;
      end else begin
         state       <= state_nxt;
         stage_rst_n <= stage_nxt;
         cause       <= cause_nxt;
         busy        <= busy_nxt;
         k           <= k_nxt;
         pre         <= pre_nxt;
         tcnt        <= tcnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      stage_nxt = stage_rst_n;
      cause_nxt = cause;
      busy_nxt  = busy;
      k_nxt     = k;
      clr       = 1'b0;
      if (req) begin
         state_nxt = HOLD;
         stage_nxt = '0;
         busy_nxt  = 1'b1;
         k_nxt     = '0;
         clr       = 1'b1;
         if (req_ext)      cause_nxt = C_EXT;
         else if (req_sw)  cause_nxt = C_SW;
         else if (req_wdt) cause_nxt = C_WDT;
         else              cause_nxt = C_SOFT;
      end else begin
         case (state)
            HOLD: begin
               if (tick && (tcnt == HOLD_LAST)) begin
                  stage_nxt = STAGES'(1);
                  clr       = 1'b1;
                  if (STAGES == 1) begin
                     state_nxt = RUN;
                     busy_nxt  = 1'b0;
                  end else begin
                     state_nxt = REL;
                     k_nxt     = KW'(1);
                  end
               end
            end
            REL: begin
               if (tick && (tcnt == GAP_LAST)) begin
                  // Bits release low-to-high, so shifting in a one releases bit k
                  stage_nxt = (stage_rst_n << 1) | STAGES'(1);
                  clr       = 1'b1;
                  if (k == K_LAST) begin
                     state_nxt = RUN;
                     busy_nxt  = 1'b0;
                  end else begin
                     k_nxt = k + KW'(1);
                  end
               end
            end
            RUN: begin
               if (kick || !WDT_ON) clr = 1'b1;
            end
            default: state_nxt = HOLD;
         endcase
      end
      if (clr || tick) pre_nxt = '0;
      else             pre_nxt = pre + PW'(1);
      if (clr)         tcnt_nxt = '0;
      else if (tick)   tcnt_nxt = tcnt + TW'(1);
      else             tcnt_nxt = tcnt;
   end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl with CLK_DIV=4, STAGES=3, T_HOLD=5, T_GAP=2, T_WDT=10.
// Watchdog scenarios follow RST_SEQ_WDT_EN, matching the design build.
module tb_rst_seq_ctrl;
   logic       clk = 1'b0;
   logic       rst_n, ext_rst_n, sw_rst_n, soft_rst_n, wdi;
   logic [2:0] stage_rst_n;
   logic [2:0] cause;
   logic       busy;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   rst_seq_ctrl #(
      .CLK_DIV(4),
      .STAGES (3),
      .T_HOLD (5),
      .T_GAP  (2),
      .T_WDT  (10)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ext_rst_n  (ext_rst_n),
      .sw_rst_n   (sw_rst_n),
      .soft_rst_n (soft_rst_n),
      .wdi        (wdi),
      .stage_rst_n(stage_rst_n),
      .cause      (cause),
      .busy       (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance n rising edges, then settle 1 ns past the edge
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Release rst_n and verify the full staged release (t=0 is the release point)
   task automatic por_seq(input string tag);
      rst_n = 1'b0;
      cyc(19);
      check({tag, "_t19_stage"}, stage_rst_n, 3'b000);
      cyc(1);
      check({tag, "_t20_stage"}, stage_rst_n, 3'b001);
      check({tag, "_t20_busy"}, busy, 1'b1);
      cyc(7);
      check({tag, "_t27_stage"}, stage_rst_n, 3'b001);
      cyc(1);
      check({tag, "_t28_stage"}, stage_rst_n, 3'b011);
      cyc(7);
      check({tag, "_t35_stage"}, stage_rst_n, 3'b011);
      check({tag, "_t35_busy"}, busy, 1'b1);
      cyc(1);
      check({tag, "_t36_stage"}, stage_rst_n, 3'b111);
      check({tag, "_t36_busy"}, busy, 1'b0);
      check({tag, "_t36_cause"}, cause, 3'd0);
   endtask

   initial begin
      rst_n      = 1'b1;
      ext_rst_n  = 1'b1;
      sw_rst_n   = 1'b1;
      soft_rst_n = 1'b1;
      wdi        = 1'b0;
      cyc(3);
      check("rst_stage", stage_rst_n, 3'b000);
      check("rst_cause", cause, 3'd0);
      check("rst_busy", busy, 1'b1);

      por_seq("por");

      // ext and sw together, 50 cycles low, from RUN
      ext_rst_n = 1'b0;
      sw_rst_n  = 1'b0;
      cyc(2);
      check("ext_t2_stage", stage_rst_n, 3'b111);
      cyc(1);
      check("ext_t3_stage", stage_rst_n, 3'b000);
      check("ext_t3_cause", cause, 3'd1);
      check("ext_t3_busy", busy, 1'b1);
      cyc(47);
      ext_rst_n = 1'b1;
      sw_rst_n  = 1'b1;
      cyc(21);
      check("ext_rel_t19_stage", stage_rst_n, 3'b000);
      cyc(1);
      check("ext_rel_t20_stage", stage_rst_n, 3'b001);
      check("ext_rel_cause", cause, 3'd1);

      // soft falling edge during REL, held low across the new HOLD
      cyc(2);
      soft_rst_n = 1'b0;
      cyc(2);
      check("soft_t2_stage", stage_rst_n, 3'b001);
      cyc(1);
      check("soft_t3_stage", stage_rst_n, 3'b000);
      check("soft_t3_cause", cause, 3'd4);
      cyc(19);
      check("soft_t22_stage", stage_rst_n, 3'b000);
      cyc(1);
      check("soft_t23_stage", stage_rst_n, 3'b001);
      cyc(7);
      soft_rst_n = 1'b1;
      cyc(1);
      check("soft_t31_stage", stage_rst_n, 3'b011);
      cyc(8);
      check("soft_t39_stage", stage_rst_n, 3'b111);
      check("soft_t39_busy", busy, 1'b0);
      check("soft_t39_cause", cause, 3'd4);

`ifdef RST_SEQ_WDT_EN
      for (int i = 0; i < 3; i++) begin
         wdi = ~wdi;
         cyc(30);
         check("wdt_kicked_stage", stage_rst_n, 3'b111);
      end
      wdi = ~wdi;
      cyc(3);
      check("wdt_last_kick_stage", stage_rst_n, 3'b111);
      cyc(39);
      check("wdt_t39_stage", stage_rst_n, 3'b111);
      cyc(1);
      check("wdt_t40_stage", stage_rst_n, 3'b000);
      check("wdt_t40_cause", cause, 3'd3);
      check("wdt_t40_busy", busy, 1'b1);
`else
      for (int i = 0; i < 4; i++) begin
         cyc(250);
         check("nowdt_stage", stage_rst_n, 3'b111);
      end
      check("nowdt_cause", cause, 3'd4);
      check("nowdt_busy", busy, 1'b0);
`endif

      // one-cycle sw pulse, then rst_n asserted mid-REL
      sw_rst_n = 1'b0;
      cyc(1);
      sw_rst_n = 1'b1;
      cyc(2);
      check("sw_t3_stage", stage_rst_n, 3'b000);
      check("sw_t3_cause", cause, 3'd2);
      cyc(20);
      check("sw_t23_stage", stage_rst_n, 3'b001);
      cyc(2);
      #2;
      rst_n = 1'b1;
      #1;
      check("async_rst_stage", stage_rst_n, 3'b000);
      check("async_rst_busy", busy, 1'b1);
      check("async_rst_cause", cause, 3'd0);
      cyc(2);
      por_seq("rerun");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
